// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded instruction fields at the
// decode/execute boundary.
// - flushIn loads a bubble: all outputs go to 0 and validOut goes to 0.
// - freezeIn holds the current contents.
// - flushIn takes priority over freezeIn when both are high.
// Optional stall counter: define ID_EXE_STALL_COUNT_EN to add stallCntOut.
module id_exe_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushIn,
    input  logic        freezeIn,
    input  logic        wbEnIn,
    input  logic        memREnIn,
    input  logic        memWEnIn,
    input  logic        bIn,
    input  logic        sIn,
    input  logic        immIn,
    input  logic [3:0]  exeCmdIn,
    input  logic [3:0]  srIn,
    input  logic [31:0] pcIn,
    input  logic [31:0] valRnIn,
    input  logic [31:0] valRmIn,
    input  logic [11:0] shiftOperandIn,
    input  logic [23:0] signedImm24In,
    input  logic [3:0]  destIn,
    input  logic [3:0]  src1In,
    input  logic [3:0]  src2In,
    output logic        wbEnOut,
    output logic        memREnOut,
    output logic        memWEnOut,
    output logic        bOut,
    output logic        sOut,
    output logic        immOut,
    output logic [3:0]  exeCmdOut,
    output logic [3:0]  srOut,
    output logic [31:0] pcOut,
    output logic [31:0] valRnOut,
    output logic [31:0] valRmOut,
    output logic [11:0] shiftOperandOut,
    output logic [23:0] signedImm24Out,
    output logic [3:0]  destOut,
    output logic [3:0]  src1Out,
    output logic [3:0]  src2Out,
`ifdef ID_EXE_STALL_COUNT_EN
    output logic [15:0] stallCntOut,
`endif
    output logic        validOut
);

    localparam int unsigned CNT_W = 16;

    // Pipeline register.
    // Every bubble (reset or flush) clears the control bits, and freeze only
    // re-holds existing contents. As a result, the control bits are already 0
    // whenever validOut is 0, so no output gating is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbEnOut         <= 1'b0;
            memREnOut       <= 1'b0;
            memWEnOut       <= 1'b0;
            bOut            <= 1'b0;
            sOut            <= 1'b0;
            immOut          <= 1'b0;
            exeCmdOut       <= 4'h0;
            srOut           <= 4'h0;
            pcOut           <= 32'h0;
            valRnOut        <= 32'h0;
            valRmOut        <= 32'h0;
            shiftOperandOut <= 12'h0;
            signedImm24Out  <= 24'h0;
            destOut         <= 4'h0;
            src1Out         <= 4'h0;
            src2Out         <= 4'h0;
            validOut        <= 1'b0;
        end else if (flushIn) begin
            wbEnOut         <= 1'b0;
            memREnOut       <= 1'b0;
            memWEnOut       <= 1'b0;
            bOut            <= 1'b0;
            sOut            <= 1'b0;
            immOut          <= 1'b0;
            exeCmdOut       <= 4'h0;
            srOut           <= 4'h0;
            pcOut           <= 32'h0;
            valRnOut        <= 32'h0;
            valRmOut        <= 32'h0;
            shiftOperandOut <= 12'h0;
            signedImm24Out  <= 24'h0;
            destOut         <= 4'h0;
            src1Out         <= 4'h0;
            src2Out         <= 4'h0;
            validOut        <= 1'b0;
        end else if (!freezeIn) begin
            wbEnOut         <= wbEnIn;
            memREnOut       <= memREnIn;
            memWEnOut       <= memWEnIn;
            bOut            <= bIn;
            sOut            <= sIn;
            immOut          <= immIn;
            exeCmdOut       <= exeCmdIn;
            srOut           <= srIn;
            pcOut           <= pcIn;
            valRnOut        <= valRnIn;
            valRmOut        <= valRmIn;
            shiftOperandOut <= shiftOperandIn;
            signedImm24Out  <= signedImm24In;
            destOut         <= destIn;
            src1Out         <= src1In;
            src2Out         <= src2In;
            validOut        <= 1'b1;
        end
    end

`ifdef ID_EXE_STALL_COUNT_EN
    // Saturating count of stall edges; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCntOut <= '0;
        end else if (freezeIn && !flushIn && (stallCntOut != {CNT_W{1'b1}})) begin
            stallCntOut <= stallCntOut + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port flushIn, input, 1, branch-taken flush; loads a bubble.
REQ-005 SHALL have port freezeIn, input, 1, hazard stall; holds current contents.
REQ-006 SHALL have ports wbEnIn/memREnIn/memWEnIn/bIn/sIn/immIn, input, 1 each, decoded control bits.
REQ-007 SHALL have ports exeCmdIn, input, 4, ALU command; srIn, input, 4, NZCV flags.
REQ-008 SHALL have ports pcIn/valRnIn/valRmIn, input, 32 each, PC and register-file read data.
REQ-009 SHALL have ports shiftOperandIn 12, signedImm24In 24, destIn 4, src1In 4, src2In 4, all input.
REQ-010 SHALL have one registered output per input field, same width, suffix Out (e.g. src1Out, src2Out).
REQ-011 SHALL have port validOut, output, 1, high when the stage holds a real instruction.

Function
REQ-012 SHALL register all fields on rising clk when rst is high; latency exactly one cycle, input to output.
REQ-013 SHALL, with flushIn=1, load the bubble value: every output 0, validOut=0.
REQ-014 SHALL, with flushIn=0 and freezeIn=1, hold every output, including validOut, unchanged.
REQ-015 SHALL, with flushIn=0 and freezeIn=0, load all inputs and set validOut=1.
REQ-016 SHALL give flushIn priority over freezeIn when both are high in the same cycle.
REQ-017 SHALL drive src1Out/src2Out/destOut/wbEnOut straight from flops, with no combinational path from any input to any output.
REQ-018 SHALL force wbEnOut, memREnOut, memWEnOut, sOut and bOut to 0 whenever validOut=0, so a bubble never writes back, touches memory, updates flags or branches.
REQ-019 SHALL NOT modify data fields in any way; values pass through bit-exact.
REQ-020 SHALL, across consecutive freeze cycles of any length, release on the first cycle with freezeIn=0, loading that cycle's inputs.

Reset
REQ-021 SHALL, on rst low, immediately clear every output and validOut to 0, independent of clk.
REQ-022 SHALL hold the reset value while rst is low, even if flushIn or freezeIn toggle.
REQ-023 SHALL make the first rising clk after rst deasserts a normal load/hold/flush edge per REQ-013..016.
REQ-024 SHALL, on reset mid-freeze or mid-flush, discard the held instruction with no recovery.

Configuration
REQ-025 SHALL, when macro ID_EXE_STALL_COUNT_EN is defined, add output stallCntOut, 16 bits.
REQ-026 SHALL increment stallCntOut by 1 on each rising clk with freezeIn=1 and flushIn=0.
REQ-027 SHALL saturate stallCntOut at 16'hFFFF; it does not wrap.
REQ-028 SHALL clear stallCntOut to 0 on reset only; flush does not clear it.
REQ-029 SHALL, when the macro is undefined, omit the stallCntOut port and its logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover basic load: reset, then drive destIn=4'h3, valRnIn=32'hDEADBEEF, wbEnIn=1, freeze/flush=0 -> next edge destOut=3, valRnOut=DEADBEEF, wbEnOut=1, validOut=1.
REQ-031 SHALL cover freeze: load src1In=4'h5, then freezeIn=1 for 3 cycles while src1In=4'hA -> src1Out stays 5; first edge after release gives src1Out=A.
REQ-032 SHALL cover flush over freeze: flushIn=1, freezeIn=1, memWEnIn=1 -> next edge all outputs 0, validOut=0.
REQ-033 SHALL cover async reset: assert rst low between clock edges with a valid instruction held -> outputs 0 before the next edge.
REQ-034 SHALL cover the stall counter (macro defined): 70000 freeze cycles -> stallCntOut=16'hFFFF; then a flush -> stallCntOut still FFFF; then reset -> stallCntOut=0.
